alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command-side front end for the behavioural ALU. Drives the ALU's opcode and data-path input, and consumes its accumulator output and carry status.
- Accepts {opcode, operand} commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues exactly one ALU operation per command and returns the 32-bit accumulator result, carry and error flag over a valid/ready response channel, in command order.
- Sits between a host or test controller and one ALU instance. It is the only driver of that ALU's opcode and operand inputs.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2).
- DW, 16, operand width; result width is 2*DW.

Ports:
- clk  in  1  rising-edge clock shared with the ALU.
- rstb  in  1  synchronous, active-high reset for this block. The ALU's own reset is generated separately at top level.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_opcode  in  4  ALU opcode.
- cmd_operand  in  DW  operand.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  2*DW  accumulator value after the operation.
- rsp_carry  out  1  ALU carry status after the operation.
- rsp_err  out  1  command carried an illegal opcode and was not executed.
- alu_opcode  out  4  to the ALU opcode input.
- alu_operand  out  DW  to the ALU data-path input.
- alu_result  in  2*DW  from the ALU data-path output (accumulator).
- alu_status  in  1  from the ALU carry status output.
- busy  out  1  state != IDLE or FIFO not empty.

Behaviour:
- Opcodes:
  - 0 hold, 1 clear, 2 all-ones, 3 div, 4 sub, 5 sub with borrow-in, 6 add, 7 add with carry-in, 8 mul, 9 and, 10 or, 11 not, 12 xor.
  - 13–15 are illegal.
  - The ALU writes carry status only on opcodes 4–7.
  - The accumulator updates at the clock edge that ends the cycle in which the opcode is applied.
- Reset (rstb=1 at a clock edge), with values present the next cycle:
  - state=IDLE, FIFO empty.
  - cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_err=0.
  - alu_opcode=0, alu_operand=0, busy=0.
  - Any in-flight command is dropped. The accumulator keeps whatever was already latched.
- FIFO:
  - push = cmd_valid & cmd_ready; cmd_ready = !full.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH. Occupancy counter ranges 0..DEPTH.
- FSM states: IDLE, ISSUE, SETTLE, RESP.
  - IDLE: if FIFO is non-empty, pop the head into op_q/operand_q, set err_q = (op ≥ 13), and go to ISSUE.
  - ISSUE (1 cycle): alu_opcode = err_q ? 0 : op_q; alu_operand = operand_q. Go to SETTLE.
  - SETTLE (1 cycle): alu_opcode=0. At the end of the cycle capture rsp_result←alu_result, rsp_carry←alu_status, rsp_err←err_q. Go to RESP.
  - RESP: rsp_valid=1 and all rsp_* held stable.
    - rsp_valid & rsp_ready with FIFO non-empty: pop and go to ISSUE (back-to-back).
    - rsp_valid & rsp_ready with FIFO empty: go to IDLE.
    - Otherwise stay.
- In every state other than ISSUE, alu_opcode=0, so the accumulator and carry hold. A stalled response never corrupts ALU state.
- An illegal opcode is never driven to the ALU. Its response returns the unchanged accumulator and carry with rsp_err=1.
- Latency: with the FSM idle and the FIFO empty, rsp_valid rises 3 cycles after the cmd handshake edge.
- Throughput: one command per 3 cycles while rsp_ready=1.
- Responses are returned strictly in command order.

Decomposition:
- Shared header alu_defs.vh: opcode constants OP_HOLD..OP_XOR, OP_LAST_LEGAL=12, FSM state encodings.
- Sub-module alu_cmd_fifo: synchronous FIFO, DEPTH x (4+DW), with push/pop/full/empty/head.
- The sequencer top holds the FSM, response registers and the ALU drive.

Test Plan:
- Sequence CLEAR(1,0), ADD(6,0x1234) -> responses 0x00000000 c=0, then 0x00001234 c=0. alu_opcode is nonzero exactly one cycle per command.
- Starting from acc=1: ADD 0xFFFF -> 0x00000000 c=1; then ADDC(7,0x0000) -> 0x00000001 c=0.
- Starting from acc=0x0100: MUL(8,0x0100) -> 0x00010000. Then XOR(12,0xFFFF) -> 0x0000FFFF.
- Starting from acc=0x1234: illegal opcode 13 -> rsp_err=1, result 0x00001234, and alu_opcode is never 13.
- Hold rsp_ready=0 and push 6 commands with DEPTH=4:
  - 1 command executes, 4 are buffered, cmd_ready drops and the 6th waits.
  - alu_result is unchanged during the stall.
  - After rsp_ready=1, all 6 responses arrive in order at 3-cycle spacing.
- Assert rstb during SETTLE -> next cycle rsp_valid=0, cmd_ready=1, busy=0, alu_opcode=0. No response is produced for the dropped command.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Opcode and FSM state definitions shared by the ALU command sequencer files.
package alu_cmd_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_HOLD  = 4'd0,
    OP_CLEAR = 4'd1,
    OP_ONES  = 4'd2,
    OP_DIV   = 4'd3,
    OP_SUB   = 4'd4,
    OP_SUBB  = 4'd5,
    OP_ADD   = 4'd6,
    OP_ADDC  = 4'd7,
    OP_MUL   = 4'd8,
    OP_AND   = 4'd9,
    OP_OR    = 4'd10,
    OP_NOT   = 4'd11,
    OP_XOR   = 4'd12
  } alu_op_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_RESP
  } seq_state_e;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head shows the oldest entry whenever empty is low.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers host commands, issues one ALU operation per command and returns
// the accumulator, carry and error flag in command order.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_opcode,
  input  logic [DW-1:0] cmd_operand,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [2*DW-1:0] rsp_result,
  output logic          rsp_carry,
  output logic          rsp_err,
  output logic [3:0]    alu_opcode,
  output logic [DW-1:0] alu_operand,
  input  logic [2*DW-1:0] alu_result,
  input  logic          alu_status,
  output logic          busy
);

  localparam int FW = 4 + DW;

  seq_state_e    state;
  logic          err_q;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_head;
  logic [3:0]    head_op;
  logic [DW-1:0] head_operand;
  logic          head_err;
  logic          rsp_fire;

  assign head_op      = fifo_head[FW-1 -: 4];
  assign head_operand = fifo_head[DW-1:0];
  assign head_err     = op_illegal(head_op);
  assign cmd_ready    = !fifo_full;
  assign fifo_push    = cmd_valid && !fifo_full;
  assign rsp_fire     = rsp_valid && rsp_ready;
  assign fifo_pop     = !fifo_empty &&
                        ((state == ST_IDLE) || ((state == ST_RESP) && rsp_fire));
  assign busy         = (state != ST_IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cmd_opcode, cmd_operand}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // The opcode is loaded on the pop edge so it is live for exactly the ISSUE
  // cycle; an illegal opcode is replaced by HOLD so the ALU never sees it.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state       <= ST_IDLE;
      err_q       <= 1'b0;
      alu_opcode  <= OP_HOLD;
      alu_operand <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_carry   <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            err_q       <= head_err;
            alu_opcode  <= head_err ? OP_HOLD : head_op;
            alu_operand <= head_operand;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_opcode <= OP_HOLD;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_status;
          rsp_err    <= err_q;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
            if (fifo_pop) begin
              err_q       <= head_err;
              alu_opcode  <= head_err ? OP_HOLD : head_op;
              alu_operand <= head_operand;
              state       <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU partner plus a transaction-level
// scoreboard that predicts each response from the accumulator semantics.
module tb_alu_cmd_sequencer;

  localparam int DW = 16;

  logic            clk;
  logic            rstb;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_opcode;
  logic [DW-1:0]   cmd_operand;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*DW-1:0] rsp_result;
  logic            rsp_carry;
  logic            rsp_err;
  logic [3:0]      alu_opcode;
  logic [DW-1:0]   alu_operand;
  logic [2*DW-1:0] alu_result;
  logic            alu_status;
  logic            busy;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] opnd;
    bit          has_lit;
    logic [31:0] lres;
    bit          lc;
    bit          lerr;
  } sb_t;

  sb_t         sb[$];
  int          acc_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nz_cycles = 0;
  int          exp_nz = 0;
  int          ready_mode = 1;
  logic [31:0] ref_acc = 32'd0;
  logic        ref_c = 1'b0;
  logic [31:0] env_acc;
  logic        env_c;
  logic        env_rst;

  alu_cmd_sequencer #(
    .DEPTH (4),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_operand (cmd_operand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_carry   (rsp_carry),
    .rsp_err     (rsp_err),
    .alu_opcode  (alu_opcode),
    .alu_operand (alu_operand),
    .alu_result  (alu_result),
    .alu_status  (alu_status),
    .busy        (busy)
  );

  // Accumulator semantics: arithmetic and logic on the low 16 bits with a
  // zero-extended result, carry only touched by opcodes 4..7.
  function automatic logic [32:0] alu_fn(input logic [31:0] acc, input logic c,
                                         input logic [3:0] op, input logic [15:0] b);
    logic [16:0] t;
    logic [31:0] r;
    logic        nc;
    r  = acc;
    nc = c;
    t  = '0;
    case (op)
      4'd1: r = '0;
      4'd2: r = '1;
      4'd3: if (b != 16'd0) r = acc / {16'd0, b};
      4'd4: begin t = {1'b0, acc[15:0]} - {1'b0, b};                r = {16'd0, t[15:0]}; nc = t[16]; end
      4'd5: begin t = {1'b0, acc[15:0]} - {1'b0, b} - {16'd0, c};   r = {16'd0, t[15:0]}; nc = t[16]; end
      4'd6: begin t = {1'b0, acc[15:0]} + {1'b0, b};                r = {16'd0, t[15:0]}; nc = t[16]; end
      4'd7: begin t = {1'b0, acc[15:0]} + {1'b0, b} + {16'd0, c};   r = {16'd0, t[15:0]}; nc = t[16]; end
      4'd8: r = {16'd0, acc[15:0]} * {16'd0, b};
      4'd9: r = {16'd0, acc[15:0] & b};
      4'd10: r = {16'd0, acc[15:0] | b};
      4'd11: r = {16'd0, ~acc[15:0]};
      4'd12: r = {16'd0, acc[15:0] ^ b};
      default: ;
    endcase
    return {nc, r};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU partner with its own reset.
  assign alu_result = env_acc;
  assign alu_status = env_c;
  always @(posedge clk) begin
    if (env_rst) {env_c, env_acc} <= 33'd0;
    else         {env_c, env_acc} <= alu_fn(env_acc, env_c, alu_opcode, alu_operand);
  end

  // Consumer: 0 = stall, 1 = always ready, 2 = random backpressure.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Compare process: every cycle out of reset, check ALU drive legality and
  // response stability, and score each accepted response against the model.
  initial begin : compare
    sb_t         e;
    logic [32:0] nxt;
    logic        exp_err;
    logic        hold_prev;
    logic [34:0] prev_rsp;
    hold_prev = 1'b0;
    prev_rsp  = '0;
    forever begin
      @(negedge clk);
      if (rstb) begin
        hold_prev = 1'b0;
        continue;
      end
      checkOutput("alu_opcode_legal", 64'(alu_opcode > 4'd12), 64'd0);
      if (alu_opcode != 4'd0) nz_cycles++;
      if (hold_prev)
        checkOutput("rsp_held", 64'({rsp_valid, rsp_err, rsp_carry, rsp_result}), 64'(prev_rsp));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          if (e.op > 4'd12) begin
            exp_err = 1'b1;
          end else begin
            exp_err = 1'b0;
            nxt = alu_fn(ref_acc, ref_c, e.op, e.opnd);
            {ref_c, ref_acc} = nxt;
            if (e.op != 4'd0) exp_nz++;
          end
          checkOutput("rsp_result", 64'(rsp_result), 64'(ref_acc));
          checkOutput("rsp_carry", 64'(rsp_carry), 64'(ref_c));
          checkOutput("rsp_err", 64'(rsp_err), 64'(exp_err));
          if (e.has_lit) begin
            checkOutput("lit_dut", 64'({rsp_err, rsp_carry, rsp_result}), 64'({e.lerr, e.lc, e.lres}));
            checkOutput("lit_model", 64'({exp_err, ref_c, ref_acc}), 64'({e.lerr, e.lc, e.lres}));
          end
          acc_cyc.push_back(cyc);
        end
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_rsp  = {rsp_valid, rsp_err, rsp_carry, rsp_result};
    end
  end

  // Drives one command from a posedge+1 drive point and returns at the next
  // drive point; hs is the index of the handshake clock edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] opnd,
                               input bit has_lit, input logic [31:0] lres,
                               input bit lc, input bit lerr, output int hs);
    sb_t e;
    int  waited;
    waited      = 0;
    hs          = -1;
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_operand = opnd;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      waited++;
      if (waited > 500) begin
        checkOutput("cmd_accept_timeout", 64'd1, 64'd0);
        cmd_valid = 1'b0;
        return;
      end
    end
    hs      = cyc + 1;
    e.op    = op;
    e.opnd  = opnd;
    e.has_lit = has_lit;
    e.lres  = lres;
    e.lc    = lc;
    e.lerr  = lerr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (n < 3000 && !(sb.size() == 0 && !busy)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 64'(n >= 3000), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int          hs;
    int          hs2;
    int          lat;
    int          n;
    int          seen;
    logic [31:0] snap;
    logic [15:0] opnd;
    sb_t         e;

    rstb        = 1'b1;
    env_rst     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_opcode  = 4'd0;
    cmd_operand = '0;
    repeat (3) @(posedge clk);
    #1;
    rstb    = 1'b0;
    env_rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_fields", 64'({rsp_result, rsp_carry, rsp_err}), 64'd0);
    checkOutput("reset_alu_drive", 64'({alu_opcode, alu_operand}), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] clear then add, latency");
    applyStimulus(4'd1, 16'h0000, 1, 32'h0000_0000, 0, 0, hs);
    applyStimulus(4'd6, 16'h1234, 1, 32'h0000_1234, 0, 0, hs2);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - hs;
        break;
      end
    end
    checkOutput("latency", 64'(lat), 64'd3);
    waitIdle();

    $display("[TB] add carry out, add with carry in");
    applyStimulus(4'd1, 16'h0000, 0, 0, 0, 0, hs);
    applyStimulus(4'd6, 16'h0001, 0, 0, 0, 0, hs);
    applyStimulus(4'd6, 16'hFFFF, 1, 32'h0000_0000, 1, 0, hs);
    applyStimulus(4'd7, 16'h0000, 1, 32'h0000_0001, 0, 0, hs);
    waitIdle();

    $display("[TB] mul and xor");
    applyStimulus(4'd1, 16'h0000, 0, 0, 0, 0, hs);
    applyStimulus(4'd6, 16'h0100, 0, 0, 0, 0, hs);
    applyStimulus(4'd8, 16'h0100, 1, 32'h0001_0000, 0, 0, hs);
    applyStimulus(4'd12, 16'hFFFF, 1, 32'h0000_FFFF, 0, 0, hs);
    waitIdle();

    $display("[TB] illegal opcode");
    applyStimulus(4'd1, 16'h0000, 0, 0, 0, 0, hs);
    applyStimulus(4'd6, 16'h1234, 0, 0, 0, 0, hs);
    applyStimulus(4'd13, 16'h5555, 1, 32'h0000_1234, 0, 1, hs);
    waitIdle();

    $display("[TB] response stall with full FIFO");
    ready_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    fork
      begin
        for (int i = 1; i <= 6; i++) applyStimulus(4'd6, 16'(i), 0, 0, 0, 0, hs);
      end
      begin
        n = 0;
        while (!rsp_valid && n < 40) begin
          @(negedge clk);
          n++;
        end
        snap = alu_result;
        repeat (10) @(negedge clk);
        checkOutput("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("stall_accepted", 64'(sb.size()), 64'd5);
        checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("stall_busy", 64'(busy), 64'd1);
        checkOutput("stall_alu_result", 64'(alu_result), 64'(snap));
        acc_cyc.delete();
        ready_mode = 1;
      end
    join
    waitIdle();
    checkOutput("stall_rsp_count", 64'(acc_cyc.size()), 64'd6);
    for (int i = 1; i < acc_cyc.size(); i++)
      checkOutput("stall_rsp_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);

    $display("[TB] reset during settle");
    applyStimulus(4'd6, 16'h0005, 0, 0, 0, 0, hs);
    n = 0;
    while (cyc != hs + 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("issue_opcode", 64'(alu_opcode), 64'd6);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    // The dropped command already reached the ALU during its ISSUE cycle.
    if (sb.size() != 0) begin
      e = sb.pop_front();
      {ref_c, ref_acc} = alu_fn(ref_acc, ref_c, e.op, e.opnd);
      exp_nz++;
    end
    @(posedge clk);
    #1;
    rstb = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mid_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("mid_reset_busy", 64'(busy), 64'd0);
    checkOutput("mid_reset_alu_opcode", 64'(alu_opcode), 64'd0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("no_rsp_after_reset", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(4'd6, 16'h0010, 0, 0, 0, 0, hs);
    waitIdle();

    $display("[TB] random traffic");
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 3))
        0:       opnd = 16'h0000;
        1:       opnd = 16'hFFFF;
        2:       opnd = 16'($urandom_range(1, 3));
        default: opnd = 16'($urandom);
      endcase
      applyStimulus(4'($urandom_range(0, 15)), opnd, 0, 0, 0, 0, hs);
    end
    ready_mode = 1;
    waitIdle();

    checkOutput("alu_op_pulses", 64'(nz_cycles), 64'(exp_nz));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
